// File: rtl/instr_loader.sv
// Boot-time instruction memory loader: byte stream -> little-endian 32-bit word writes.
// Define LOADER_CSUM_EN to require a trailing XOR checksum byte after the image.
module instr_loader #(
    parameter int Nbits  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [Nbits-1:0]  wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

`ifdef LOADER_CSUM_EN
    localparam state_t S_FIN = S_CSUM;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t              state_q, state_d;
    logic [15:0]         n_q, n_d;
    logic [ADDR_W:0]     word_idx_q, word_idx_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         word_q, word_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [Nbits-1:0]    wdata_q, wdata_d;
    logic [7:0]          csum_q, csum_d;
    logic                accept;
    logic [15:0]         n_full;
    logic [16:0]         next_idx;

    assign accept   = rx_valid && rx_ready;
    assign n_full   = {rx_data, n_q[7:0]};
    assign next_idx = 17'(word_idx_q) + 17'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            csum_q     <= csum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        csum_d     = csum_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    csum_d     = '0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    n_d     = {8'h00, rx_data};
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    n_d = n_full;
                    if (n_full == 16'd0) begin
                        state_d = S_FIN;
                    end else if ({1'b0, n_full} > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    // Bytes shift in from the top so the first byte ends up in the low lane.
                    word_d     = {rx_data, word_q[23:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
                    csum_d     = csum_q ^ rx_data;
                    if (byte_idx_q == 2'd3) begin
                        waddr_d = word_idx_q[ADDR_W-1:0];
                        wdata_d = Nbits'({rx_data, word_q});
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = next_idx[ADDR_W:0];
                byte_idx_d = '0;
                state_d    = (next_idx == {1'b0, n_q}) ? S_FIN : S_DATA;
            end
`ifdef LOADER_CSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_LEN0, S_LEN1, S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef LOADER_CSUM_EN
            S_CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            S_WRITE: busy = 1'b1;
            default: ;
        endcase
        we       = (state_q == S_WRITE);
        done     = (state_q == S_DONE);
        err      = (state_q == S_ERR);
        cpu_hold = (state_q != S_DONE);
        waddr    = waddr_q;
        wdata    = wdata_q;
    end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader against a byte-stream reference model.
`timescale 1ns/1ps
module tb_instr_loader;

    localparam int ADDR_W = 8;
    localparam int MAXW   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready, we, busy, done, err, cpu_hold;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    instr_loader #(.Nbits(32), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the stream by byte count, not by loader states.
    typedef enum {P_IDLE, P_LOAD, P_DONE, P_ERR} phase_t;
    phase_t      m_phase = P_IDLE;
    int          m_cnt = 0, m_n = 0, m_words = 0;
    logic [31:0] m_word = '0;
    logic [7:0]  m_x = '0;
    logic        m_we = 1'b0, m_csum_wait = 1'b0;
    logic [31:0] m_waddr = '0, m_wdata = '0;
    logic [31:0] log_a[$], log_d[$];

    task automatic model_finish();
`ifdef LOADER_CSUM_EN
        m_csum_wait = 1'b1;
`else
        m_phase = P_DONE;
`endif
    endtask

    task automatic model_byte(input logic [7:0] b);
        int lane;
        if (m_cnt == 0) begin
            m_n = int'(b);
        end else if (m_cnt == 1) begin
            m_n = m_n + (int'(b) << 8);
            if (m_n == 0) model_finish();
            else if (m_n > MAXW) m_phase = P_ERR;
        end else if (m_csum_wait) begin
            m_phase = (b == m_x) ? P_DONE : P_ERR;
        end else begin
            lane = (m_cnt - 2) % 4;
            m_word[8*lane +: 8] = b;
            m_x = m_x ^ b;
            if (lane == 3) begin
                m_we    = 1'b1;
                m_waddr = 32'(m_words);
                m_wdata = m_word;
                m_words++;
            end
        end
        m_cnt++;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk1("rst_rx_ready", rx_ready, 1'b0);
            chk1("rst_we", we, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_done", done, 1'b0);
            chk1("rst_err", err, 1'b0);
            chk1("rst_cpu_hold", cpu_hold, 1'b1);
            chk("rst_waddr", 32'(waddr), 32'h0);
            chk("rst_wdata", wdata, 32'h0);
            m_phase = P_IDLE;
            m_we = 1'b0;
            m_csum_wait = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            chk1("we", we, m_we);
            chk1("rx_ready", rx_ready, (m_phase == P_LOAD) && !m_we);
            chk1("busy", busy, m_phase == P_LOAD);
            chk1("done", done, m_phase == P_DONE);
            chk1("err", err, m_phase == P_ERR);
            chk1("cpu_hold", cpu_hold, m_phase != P_DONE);
            chk("waddr", 32'(waddr), m_waddr);
            chk("wdata", wdata, m_wdata);
            if (we) begin
                log_a.push_back(32'(waddr));
                log_d.push_back(wdata);
            end
            if (m_we) begin
                m_we = 1'b0;
                if (m_words == m_n) model_finish();
            end else if (m_phase != P_LOAD) begin
                if (start) begin
                    m_phase = P_LOAD;
                    m_cnt = 0;
                    m_words = 0;
                    m_word = '0;
                    m_x = '0;
                    m_csum_wait = 1'b0;
                end
            end else if (rx_valid) begin
                model_byte(rx_data);
            end
        end
    end

    logic [7:0] img[$];
    bit         pulse_en = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        int guard;
        g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
        for (int i = 0; i < g; i++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            start    = pulse_en && ($urandom_range(3, 0) == 0);
            tick();
            start = 1'b0;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!rx_ready && guard < 50);
        chk1("accept_within_bound", rx_ready, 1'b1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_end();
        int guard;
        guard = 0;
        while (!(done || err) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk1("load_end_within_bound", done || err, 1'b1);
        tick();
    endtask

    task automatic run_img(input int gap);
        foreach (img[i]) send_byte(img[i], gap);
        wait_end();
    endtask

    task automatic build(input int n, input bit bad_csum);
        logic [7:0] x;
        logic [7:0] b;
        img = {};
        x = 8'h00;
        img.push_back(8'(n));
        img.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            img.push_back(b);
        end
`ifdef LOADER_CSUM_EN
        img.push_back(bad_csum ? (x ^ 8'h5A) : x);
`else
        if (bad_csum) x = 8'h00;
`endif
    endtask

    initial begin
        tick();
        tick();
        chk1("reset_cpu_hold", cpu_hold, 1'b1);
        chk1("reset_rx_ready", rx_ready, 1'b0);
        rst_n = 1'b1;
        tick();
        do_start();
        @(negedge clk);
        chk1("ready_after_start", rx_ready, 1'b1);
        tick();

        // Directed two-word image
        log_a.delete(); log_d.delete();
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
`ifdef LOADER_CSUM_EN
        img.push_back(8'h30);
`endif
        run_img(0);
        chk("n2_model_pin", m_wdata, 32'h00100593);
        chk("n2_count", 32'(log_a.size()), 32'd2);
        if (log_a.size() == 2) begin
            chk("n2_addr0", log_a[0], 32'd0);
            chk("n2_data0", log_d[0], 32'h00A00513);
            chk("n2_addr1", log_a[1], 32'd1);
            chk("n2_data1", log_d[1], 32'h00100593);
        end
        chk1("n2_done", done, 1'b1);
        chk1("n2_cpu_hold", cpu_hold, 1'b0);
        chk1("n2_busy", busy, 1'b0);

        // Same image with gaps and stray start pulses
        log_a.delete(); log_d.delete();
        pulse_en = 1'b1;
        do_start();
        run_img(3);
        pulse_en = 1'b0;
        chk("gap_count", 32'(log_a.size()), 32'd2);
        if (log_d.size() == 2) chk("gap_data1", log_d[1], 32'h00100593);

        // N = 0
        log_a.delete(); log_d.delete();
        build(0, 1'b0);
        do_start();
        run_img(0);
        chk("n0_writes", 32'(log_a.size()), 32'd0);
        chk1("n0_done", done, 1'b1);

        // N = 257 overflows the memory
        log_a.delete(); log_d.delete();
        img = '{8'h01, 8'h01};
        do_start();
        run_img(0);
        chk1("n257_err", err, 1'b1);
        chk1("n257_hold", cpu_hold, 1'b1);
        chk("n257_writes", 32'(log_a.size()), 32'd0);

        // N = 256 fills the memory exactly
        log_a.delete(); log_d.delete();
        build(MAXW, 1'b0);
        do_start();
        run_img(0);
        chk("n256_count", 32'(log_a.size()), 32'd256);
        if (log_a.size() > 0) chk("n256_last_addr", log_a[log_a.size()-1], 32'd255);
        chk1("n256_done", done, 1'b1);

        // Reset in the middle of a load
        build(3, 1'b0);
        do_start();
        for (int i = 0; i < 8; i++) send_byte(img[i], 1);
        rst_n = 1'b0;
        #1;
        chk1("midrst_hold", cpu_hold, 1'b1);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_ready", rx_ready, 1'b0);
        chk1("midrst_done", done, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        log_a.delete(); log_d.delete();
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CSUM_EN
        img.push_back(8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
`endif
        do_start();
        run_img(1);
        chk("after_rst_count", 32'(log_a.size()), 32'd1);
        if (log_a.size() == 1) begin
            chk("after_rst_addr", log_a[0], 32'd0);
            chk("after_rst_data", log_d[0], 32'hDEADBEEF);
        end

`ifdef LOADER_CSUM_EN
        img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        do_start();
        run_img(0);
        chk1("csum_ok_done", done, 1'b1);
        img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
        do_start();
        run_img(0);
        chk1("csum_bad_err", err, 1'b1);
        chk1("csum_bad_hold", cpu_hold, 1'b1);
`endif

        // Random images
        for (int r = 0; r < 8; r++) begin
            build(int'($urandom_range(8, 1)), ($urandom_range(3, 0) == 0));
            pulse_en = 1'b1;
            do_start();
            run_img(3);
            pulse_en = 1'b0;
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
